// File: rtl/register_file_pkg.sv
// Processor-wide register file constants: geometry, the hardwired zero index and
// the MIPS ABI register names.
package register_file_pkg;

    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_COUNT      = 2 ** REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] regAddr_t;
    typedef logic [REG_DATA_WIDTH-1:0] regData_t;

    localparam regAddr_t REG_ZERO = 5'd0;

    // MIPS ABI names for commonly used registers.
    localparam regAddr_t REG_T0 = 5'd8;
    localparam regAddr_t REG_T1 = 5'd9;
    localparam regAddr_t REG_T2 = 5'd10;
    localparam regAddr_t REG_T3 = 5'd11;
    localparam regAddr_t REG_T4 = 5'd12;
    localparam regAddr_t REG_T5 = 5'd13;
    localparam regAddr_t REG_T6 = 5'd14;
    localparam regAddr_t REG_T7 = 5'd15;
    localparam regAddr_t REG_S0 = 5'd16;
    localparam regAddr_t REG_S1 = 5'd17;
    localparam regAddr_t REG_S2 = 5'd18;
    localparam regAddr_t REG_S3 = 5'd19;
    localparam regAddr_t REG_S4 = 5'd20;
    localparam regAddr_t REG_S5 = 5'd21;
    localparam regAddr_t REG_S6 = 5'd22;
    localparam regAddr_t REG_S7 = 5'd23;
    localparam regAddr_t REG_T8 = 5'd24;
    localparam regAddr_t REG_T9 = 5'd25;
    localparam regAddr_t REG_RA = 5'd31;

    // Index 0 is hardwired to zero, so it is never a legal write target.
    function automatic logic isWritable(input regAddr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Register file access bus: two combinational read ports and one clocked write port.
interface register_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);

    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;

    modport master (
        output ReadRegister1,
        output ReadRegister2,
        output WriteRegister,
        output WriteData,
        output RegWrite,
        input  ReadData1,
        input  ReadData2
    );

    modport slave (
        input  ReadRegister1,
        input  ReadRegister2,
        input  WriteRegister,
        input  WriteData,
        input  RegWrite,
        output ReadData1,
        output ReadData2
    );

endinterface

// File: rtl/register_file.sv
// 32 x 32-bit MIPS general-purpose register file; register 0 reads as zero and
// ignores writes. Reads are combinational with no write-to-read bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic            Clk,
    input  logic            Rst,
    register_file_if.slave  bus
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [Depth];
    logic                  writeEn;

    assign writeEn = bus.RegWrite && (bus.WriteRegister != '0);

    // Reset wins over a concurrent write.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[bus.WriteRegister] <= bus.WriteData;
        end
    end

    // Index 0 is forced to zero so its value never depends on stored state.
    assign bus.ReadData1 = (bus.ReadRegister1 == '0) ? '0 : regs[bus.ReadRegister1];
    assign bus.ReadData2 = (bus.ReadRegister2 == '0) ? '0 : regs[bus.ReadRegister2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, zero register, fill/readback,
// overwrite, write disable, read-during-write and reset priority.
module tb_register_file;
    import register_file_pkg::*;

    logic Clk;
    logic Rst;
    int   compared;
    int   mismatched;

    logic [31:0] model [32];

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #100 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #5;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic readPair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        bus.ReadRegister1 = a1;
        bus.ReadRegister2 = a2;
        #1;
        check($sformatf("%s port1 r%0d", tag, a1), bus.ReadData1, model[a1]);
        check($sformatf("%s port2 r%0d", tag, a2), bus.ReadData2, model[a2]);
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = addr;
        bus.WriteData     = data;
        tick();
        if (addr != 5'd0) model[addr] = data;
        bus.RegWrite = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        Rst               = 1'b1;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = 5'd0;
        bus.WriteData     = 32'h0;
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd0;

        // Reset: every register reads zero.
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 32; i += 2) readPair("reset", 5'(i), 5'(i + 1));

        // Zero register ignores writes.
        writeReg(5'd0, 32'hABCDEF98);
        bus.ReadRegister1 = 5'd0;
        #1;
        check("zero reg", bus.ReadData1, 32'h00000000);

        // Fill 8..25 and 31.
        writeReg(5'd8, 32'h0ECE274A);
        writeReg(5'd9, 32'h00002222);
        for (int i = 10; i < 24; i++) writeReg(5'(i), 32'h1000_0000 + 32'(i));
        writeReg(5'd24, 32'hF1E2FFFF);
        writeReg(5'd25, 32'h2F1EFFFF);
        writeReg(5'd31, 32'd1000);

        readPair("fill", 5'd8, 5'd9);
        readPair("fill", 5'd24, 5'd25);
        readPair("fill", 5'd21, 5'd31);
        bus.ReadRegister1 = 5'd8;
        bus.ReadRegister2 = 5'd8;
        #1;
        check("same idx port1", bus.ReadData1, 32'h0ECE274A);
        check("same idx port2", bus.ReadData2, 32'h0ECE274A);
        check("fill r31", model[31], 32'd1000);

        // Overwrite.
        writeReg(5'd21, 32'h0000FFEE);
        writeReg(5'd21, 32'h00000014);
        bus.ReadRegister1 = 5'd21;
        bus.ReadRegister2 = 5'd20;
        #1;
        check("overwrite r21", bus.ReadData1, 32'h00000014);
        check("neighbour r20", bus.ReadData2, 32'h10000014);

        // Write disabled: nothing changes.
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = 5'd9;
        bus.WriteData     = 32'hDEADBEEF;
        tick();
        tick();
        tick();
        bus.ReadRegister1 = 5'd9;
        #1;
        check("disabled r9", bus.ReadData1, 32'h00002222);

        // Read during write: old value before the edge, new value after.
        bus.ReadRegister1 = 5'd10;
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd10;
        bus.WriteData     = 32'h12345678;
        #1;
        check("rdw before", bus.ReadData1, 32'h1000000A);
        tick();
        bus.RegWrite = 1'b0;
        check("rdw after", bus.ReadData1, 32'h12345678);
        model[10] = 32'h12345678;

        // Reset has priority over a concurrent write.
        Rst               = 1'b1;
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd5;
        bus.WriteData     = 32'hFFFFFFFF;
        tick();
        Rst          = 1'b0;
        bus.RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 32; i += 2) readPair("rst prio", 5'(i), 5'(i + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
